// File: rtl/difftest_sim_monitor_pkg.sv
// rtl/difftest_sim_monitor_pkg.sv - shared types and constants for the difftest simulation monitor
// Purpose: run-state and termination-cause encodings, exit/DPI result
// constants, and a helper that sizes core-index fields.
package difftest_sim_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE        = 3'd0,
    CAUSE_EXIT_OK     = 3'd1,
    CAUSE_EXIT_ERR    = 3'd2,
    CAUSE_MAX_CYCLES  = 3'd3,
    CAUSE_STUCK       = 3'd4,
    CAUSE_SIMV_FAIL   = 3'd5,
    CAUSE_SIMV_DONE   = 3'd6,
    CAUSE_INSTR_LIMIT = 3'd7
  } cause_e;

  localparam logic [63:0] EXIT_OK   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [7:0]  SIMV_DONE = 8'h1;
  localparam logic [7:0]  SIMV_FAIL = 8'h2;

  // A single-core build still needs a one-bit core index field.
  function automatic int core_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/difftest_uart_fifo.sv
// rtl/difftest_uart_fifo.sv - synchronous FIFO for the monitor UART path
// Purpose: DEPTH-entry first-word-fall-through FIFO; a push while full is
// accepted when a pop happens on the same edge.
// Ports:
//   clock, reset         sole clock, synchronous active-high reset
//   push, push_data      write request and data
//   pop                  read request (ignored when empty)
//   pop_data             head entry, valid while !empty
//   full, empty          occupancy flags
module difftest_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/difftest_sim_monitor.sv
// rtl/difftest_sim_monitor.sv - multi-core difftest run/pass/fail monitor with UART aggregation
// Purpose: watches per-core step/exit/UART signals, runs cycle-limit and
// stuck detection, and holds a sticky IDLE/RUN/PASS/FAIL state for the
// simulation wrapper to poll.
// Optional feature macro: DIFFTEST_SIM_MONITOR_INSTR_LIMIT_EN adds
// max_instrs/n_instrs and an instruction-count PASS (cause 7).
// Ports:
//   clock, reset                     sole clock, synchronous active-high reset
//   step                             per-core committed instructions this cycle
//   exit_code                        per-core exit (0 run, all-ones ok, else error)
//   uart_valid, uart_ch              per-core UART bytes
//   max_cycles, stuck_limit          limits, 0 disables
//   simv_result                      DPI result (1 done, 2 fail)
//   uo_valid, uo_ready, uo_ch, uo_core  aggregated UART stream
//   state, cause, cause_core, err_code  sticky outcome
//   n_cycles, uart_drops, perf_dump  status counters and end pulse
module difftest_sim_monitor
  import difftest_sim_monitor_pkg::*;
#(
  parameter int  NUM_CORES  = 2,
  parameter int  STEP_W     = 8,
  parameter int  CNT_W      = 64,
  parameter int  UART_DEPTH = 16,
  localparam int CORE_W     = core_w(NUM_CORES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CORES*STEP_W-1:0] step,
  input  logic [NUM_CORES*64-1:0]   exit_code,
  input  logic [NUM_CORES-1:0]      uart_valid,
  input  logic [NUM_CORES*8-1:0]    uart_ch,
  input  logic [CNT_W-1:0]          max_cycles,
  input  logic [CNT_W-1:0]          stuck_limit,
  input  logic [7:0]                simv_result,
  output logic                      uo_valid,
  input  logic                      uo_ready,
  output logic [7:0]                uo_ch,
  output logic [CORE_W-1:0]         uo_core,
  output logic [1:0]                state,
  output logic [2:0]                cause,
  output logic [CORE_W-1:0]         cause_core,
  output logic [63:0]               err_code,
  output logic [CNT_W-1:0]          n_cycles,
  output logic [15:0]               uart_drops,
`ifdef DIFFTEST_SIM_MONITOR_INSTR_LIMIT_EN
  input  logic [CNT_W-1:0]          max_instrs,
  output logic [CNT_W-1:0]          n_instrs,
`endif
  output logic                      perf_dump
);

  state_e              state_q;
  cause_e              cause_q;
  logic [CNT_W-1:0]    stuck_timer [NUM_CORES];

  // ---------------- termination detection ----------------
  logic                exit_err_hit;
  logic [CORE_W-1:0]   exit_err_core;
  logic [63:0]         exit_err_code;
  logic                all_exit_ok;
  logic                stuck_hit;
  logic [CORE_W-1:0]   stuck_core;
  logic                max_cyc_hit;
  logic                instr_hit;

  // Descending scan so the lowest-index offender is the one left latched.
  always_comb begin
    exit_err_hit  = 1'b0;
    exit_err_core = '0;
    exit_err_code = '0;
    all_exit_ok   = 1'b1;
    stuck_hit     = 1'b0;
    stuck_core    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (exit_code[i*64 +: 64] != 64'd0 && exit_code[i*64 +: 64] != EXIT_OK) begin
        exit_err_hit  = 1'b1;
        exit_err_core = CORE_W'(i);
        exit_err_code = exit_code[i*64 +: 64];
      end
      if (exit_code[i*64 +: 64] != EXIT_OK) begin
        all_exit_ok = 1'b0;
      end
      if (stuck_limit != '0 && stuck_timer[i] >= stuck_limit) begin
        stuck_hit  = 1'b1;
        stuck_core = CORE_W'(i);
      end
    end
  end

  assign max_cyc_hit = (max_cycles != '0) && (n_cycles >= max_cycles);

`ifdef DIFFTEST_SIM_MONITOR_INSTR_LIMIT_EN
  logic [STEP_W+4:0]   step_sum;
  logic [CNT_W:0]      instr_next;

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      step_sum = step_sum + (STEP_W+5)'(step[i*STEP_W +: STEP_W]);
    end
  end

  assign instr_next = {1'b0, n_instrs} + (CNT_W+1)'(step_sum);
  assign instr_hit  = (max_instrs != '0) && (n_instrs >= max_instrs);

  always_ff @(posedge clock) begin
    if (reset) begin
      n_instrs <= '0;
    end else if (state_q == ST_RUN) begin
      n_instrs <= instr_next[CNT_W] ? '1 : instr_next[CNT_W-1:0];
    end
  end
`else
  assign instr_hit = 1'b0;
`endif

  logic                term_hit;
  state_e              term_state;
  cause_e              term_cause;
  logic [CORE_W-1:0]   term_core;
  logic [63:0]         term_code;

  always_comb begin
    term_hit   = 1'b1;
    term_state = ST_FAIL;
    term_cause = CAUSE_NONE;
    term_core  = '0;
    term_code  = '0;
    if (exit_err_hit) begin
      term_cause = CAUSE_EXIT_ERR;
      term_core  = exit_err_core;
      term_code  = exit_err_code;
    end else if (simv_result == SIMV_FAIL) begin
      term_cause = CAUSE_SIMV_FAIL;
    end else if (stuck_hit) begin
      term_cause = CAUSE_STUCK;
      term_core  = stuck_core;
    end else if (max_cyc_hit) begin
      term_cause = CAUSE_MAX_CYCLES;
    end else if (all_exit_ok) begin
      term_state = ST_PASS;
      term_cause = CAUSE_EXIT_OK;
    end else if (instr_hit) begin
      term_state = ST_PASS;
      term_cause = CAUSE_INSTR_LIMIT;
    end else if (simv_result == SIMV_DONE) begin
      term_state = ST_PASS;
      term_cause = CAUSE_SIMV_DONE;
    end else begin
      term_hit   = 1'b0;
      term_state = ST_RUN;
    end
  end

  // ---------------- run state machine ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      cause_core <= '0;
      err_code   <= '0;
      n_cycles   <= '0;
      perf_dump  <= 1'b0;
    end else begin
      perf_dump <= 1'b0;
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        ST_RUN: begin
          if (n_cycles != '1) begin
            n_cycles <= n_cycles + CNT_W'(1);
          end
          if (term_hit) begin
            state_q    <= term_state;
            cause_q    <= term_cause;
            cause_core <= term_core;
            err_code   <= term_code;
            perf_dump  <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign state = state_q;
  assign cause = cause_q;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (reset) begin
        stuck_timer[i] <= '0;
      end else if (state_q == ST_RUN) begin
        if (step[i*STEP_W +: STEP_W] != '0) begin
          stuck_timer[i] <= '0;
        end else if (stuck_timer[i] != '1) begin
          stuck_timer[i] <= stuck_timer[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- UART aggregation ----------------
  logic [CORE_W-1:0]      rr_ptr;
  logic [2*NUM_CORES-1:0] valid_rot;
  logic                   grant_valid;
  logic [CORE_W-1:0]      grant_off;
  logic [CORE_W:0]        grant_sum;
  logic [CORE_W-1:0]      grant_core;
  logic [7:0]             grant_ch;
  logic [4:0]             n_valid;
  logic [4:0]             drop_cnt;
  logic [16:0]            drops_sum;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   push_accept;
  logic [CORE_W+7:0]      fifo_rd;

  // Rotating the doubled valid vector by rr_ptr puts the preferred core at
  // bit 0; the first set bit is the grant offset from the pointer.
  assign valid_rot = {uart_valid, uart_valid} >> rr_ptr;

  always_comb begin
    grant_valid = 1'b0;
    grant_off   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_valid = 1'b1;
        grant_off   = CORE_W'(k);
      end
    end
  end

  assign grant_sum  = {1'b0, rr_ptr} + {1'b0, grant_off};
  assign grant_core = (grant_sum >= (CORE_W+1)'(NUM_CORES))
                    ? CORE_W'(grant_sum - (CORE_W+1)'(NUM_CORES))
                    : grant_sum[CORE_W-1:0];

  always_comb begin
    grant_ch = '0;
    n_valid  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (CORE_W'(k) == grant_core) begin
        grant_ch = uart_ch[k*8 +: 8];
      end
      n_valid = n_valid + {4'd0, uart_valid[k]};
    end
  end

  assign fifo_pop    = uo_valid && uo_ready;
  assign push_accept = grant_valid && (!fifo_full || fifo_pop);
  // Every valid byte not actually written is a drop, granted or not.
  assign drop_cnt    = n_valid - {4'd0, push_accept};
  assign drops_sum   = {1'b0, uart_drops} + {12'd0, drop_cnt};

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      uart_drops <= '0;
    end else begin
      if (grant_valid) begin
        rr_ptr <= (grant_core == CORE_W'(NUM_CORES - 1)) ? '0 : grant_core + CORE_W'(1);
      end
      uart_drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
    end
  end

  difftest_uart_fifo #(
    .WIDTH (CORE_W + 8),
    .DEPTH (UART_DEPTH)
  ) u_uart_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant_valid),
    .push_data ({grant_core, grant_ch}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign uo_valid = !fifo_empty;
  assign uo_core  = fifo_rd[CORE_W+7:8];
  assign uo_ch    = fifo_rd[7:0];

endmodule

// File: tb/tb_difftest_sim_monitor.sv
// tb/tb_difftest_sim_monitor.sv - self-checking bench for difftest_sim_monitor
module tb_difftest_sim_monitor;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  step;
  logic [127:0] exit_code;
  logic [1:0]   uart_valid;
  logic [15:0]  uart_ch;
  logic [63:0]  max_cycles;
  logic [63:0]  stuck_limit;
  logic [7:0]   simv_result;
  logic         uo_valid;
  logic         uo_ready;
  logic [7:0]   uo_ch;
  logic [0:0]   uo_core;
  logic [1:0]   state;
  logic [2:0]   cause;
  logic [0:0]   cause_core;
  logic [63:0]  err_code;
  logic [63:0]  n_cycles;
  logic [15:0]  uart_drops;
  logic         perf_dump;
`ifdef DIFFTEST_SIM_MONITOR_INSTR_LIMIT_EN
  logic [63:0]  max_instrs = '0;
  logic [63:0]  n_instrs;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q [$];
  int         m_rr    = 0;
  int         m_drops = 0;

  difftest_sim_monitor dut (
    .clock       (clock),
    .reset       (reset),
    .step        (step),
    .exit_code   (exit_code),
    .uart_valid  (uart_valid),
    .uart_ch     (uart_ch),
    .max_cycles  (max_cycles),
    .stuck_limit (stuck_limit),
    .simv_result (simv_result),
    .uo_valid    (uo_valid),
    .uo_ready    (uo_ready),
    .uo_ch       (uo_ch),
    .uo_core     (uo_core),
    .state       (state),
    .cause       (cause),
    .cause_core  (cause_core),
    .err_code    (err_code),
    .n_cycles    (n_cycles),
    .uart_drops  (uart_drops),
`ifdef DIFFTEST_SIM_MONITOR_INSTR_LIMIT_EN
    .max_instrs  (max_instrs),
    .n_instrs    (n_instrs),
`endif
    .perf_dump   (perf_dump)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge with inputs set; compares the UART stream
  // against the scoreboard, updates the model, then advances one cycle.
  task automatic cycle();
    logic [8:0] e;
    int         g;
    int         nv;
    if (!reset) begin
      check_eq("uo_valid", uo_valid, exp_q.size() != 0);
    end
    if (reset) begin
      exp_q.delete();
      m_rr    = 0;
      m_drops = 0;
    end else begin
      if (uo_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("uo_core", uo_core, e[8]);
        check_eq("uo_ch", uo_ch, e[7:0]);
      end
      g  = -1;
      nv = 0;
      for (int k = 0; k < 2; k++) begin
        int c;
        c = (m_rr + k) % 2;
        if (g < 0 && uart_valid[c]) g = c;
        if (uart_valid[k]) nv++;
      end
      if (g >= 0) begin
        m_rr = (g + 1) % 2;
        if (exp_q.size() < 16) begin
          exp_q.push_back({g[0], (g == 0) ? uart_ch[7:0] : uart_ch[15:8]});
          nv--;
        end
      end
      m_drops = m_drops + nv;
      if (m_drops > 16'hFFFF) m_drops = 16'hFFFF;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    step        = '0;
    exit_code   = '0;
    uart_valid  = '0;
    uart_ch     = '0;
    max_cycles  = '0;
    stuck_limit = '0;
    simv_result = '0;
    uo_ready    = 1'b0;
    repeat (3) cycle();
    check_eq("rst_state", state, 0);
    check_eq("rst_cause", cause, 0);
    check_eq("rst_cause_core", cause_core, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_n_cycles", n_cycles, 0);
    check_eq("rst_drops", uart_drops, 0);
    check_eq("rst_uo_valid", uo_valid, 0);
    check_eq("rst_perf_dump", perf_dump, 0);
    reset = 1'b0;
    cycle();
    check_eq("enter_run", state, 1);
    check_eq("run_n_cycles0", n_cycles, 0);
  endtask

  initial begin
    @(negedge clock);

    // idle run: cycle counter
    do_reset();
    repeat (10) cycle();
    check_eq("n_cycles10", n_cycles, 10);
    check_eq("idle_state", state, 1);
    check_eq("idle_perf", perf_dump, 0);

    // exit error on core 1
    do_reset();
    repeat (20) cycle();
    exit_code[127:64] = 64'h5;
    cycle();
    check_eq("err_state", state, 3);
    check_eq("err_cause", cause, 2);
    check_eq("err_core", cause_core, 1);
    check_eq("err_code", err_code, 64'h5);
    check_eq("err_perf1", perf_dump, 1);
    check_eq("err_n_cycles", n_cycles, 21);
    exit_code = '1;
    cycle();
    check_eq("err_perf0", perf_dump, 0);
    repeat (5) cycle();
    check_eq("err_sticky_state", state, 3);
    check_eq("err_sticky_cause", cause, 2);
    check_eq("err_sticky_code", err_code, 64'h5);
    check_eq("err_frozen_cycles", n_cycles, 21);
    check_eq("err_perf_quiet", perf_dump, 0);

    // stuck core 1
    do_reset();
    stuck_limit = 64'd50;
    step = 16'h0001;
    repeat (50) cycle();
    check_eq("stuck_pre", state, 1);
    cycle();
    check_eq("stuck_state", state, 3);
    check_eq("stuck_cause", cause, 4);
    check_eq("stuck_core", cause_core, 1);
    check_eq("stuck_perf", perf_dump, 1);

    // periodic steps keep core 1 alive
    do_reset();
    stuck_limit = 64'd50;
    for (int i = 0; i < 200; i++) begin
      step = (i % 40 == 39) ? 16'h0101 : 16'h0001;
      cycle();
    end
    check_eq("alive_state", state, 1);
    check_eq("alive_cause", cause, 0);

    // normal exit: both cores required
    do_reset();
    repeat (30) cycle();
    exit_code[63:0] = '1;
    repeat (15) cycle();
    check_eq("partial_exit", state, 1);
    exit_code[127:64] = '1;
    cycle();
    check_eq("pass_state", state, 2);
    check_eq("pass_cause", cause, 1);
    check_eq("pass_core", cause_core, 0);
    check_eq("pass_err_code", err_code, 0);
    check_eq("pass_perf", perf_dump, 1);

    // UART overflow with stalled consumer
    do_reset();
    for (int i = 0; i < 40; i++) begin
      uart_valid = 2'b11;
      uart_ch    = 16'($urandom);
      cycle();
    end
    uart_valid = '0;
    cycle();
    check_eq("drops64", uart_drops, 64);
    check_eq("drops_model", uart_drops, m_drops);
    uo_ready = 1'b1;
    repeat (18) cycle();
    check_eq("drained", uo_valid, 0);

    // full FIFO with simultaneous push and pop loses nothing
    uo_ready = 1'b0;
    uart_valid = 2'b01;
    for (int i = 0; i < 16; i++) begin
      uart_ch = 16'($urandom);
      cycle();
    end
    check_eq("full_valid", uo_valid, 1);
    uo_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      uart_ch = 16'($urandom);
      cycle();
    end
    check_eq("pushpop_drops", uart_drops, 64);
    uart_valid = '0;
    repeat (20) cycle();
    check_eq("drained2", uo_valid, 0);

    // reset with bytes still queued clears the FIFO
    uo_ready = 1'b0;
    uart_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      uart_ch = 16'($urandom);
      cycle();
    end
    check_eq("queued_before_reset", uo_valid, 1);
    do_reset();

    // simv fail outranks max cycles
    do_reset();
    max_cycles = 64'd100;
    repeat (100) cycle();
    check_eq("maxc_pre", state, 1);
    check_eq("maxc_n", n_cycles, 100);
    simv_result = 8'h2;
    cycle();
    check_eq("simvf_state", state, 3);
    check_eq("simvf_cause", cause, 5);
    check_eq("simvf_core", cause_core, 0);

    // max cycles alone
    do_reset();
    max_cycles = 64'd100;
    repeat (99) cycle();
    cycle();
    check_eq("maxc_edge", state, 1);
    cycle();
    check_eq("maxc_state", state, 3);
    check_eq("maxc_cause", cause, 3);

    // simv done, then sticky against a later simv fail
    do_reset();
    repeat (5) cycle();
    simv_result = 8'h1;
    cycle();
    check_eq("simvd_state", state, 2);
    check_eq("simvd_cause", cause, 6);
    simv_result = 8'h2;
    repeat (3) cycle();
    check_eq("simvd_sticky", state, 2);
    check_eq("simvd_sticky_cause", cause, 6);

    // exit error outranks simv fail; lowest core wins
    do_reset();
    exit_code   = {64'h9, 64'h7};
    simv_result = 8'h2;
    cycle();
    check_eq("prio_cause", cause, 2);
    check_eq("prio_core", cause_core, 0);
    check_eq("prio_code", err_code, 64'h7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/difftest_sim_monitor.md
Name: difftest_sim_monitor

Overview:
- Synthesizable, multi-core successor to the simulation endpoint control logic.
- Aggregates per-core difftest step, exit and UART signals and runs cycle-limit and per-core stuck detection.
- Drives a sticky run/pass/fail state machine that the DPI-C wrapper polls.
- Sits between the DUT difftest top IO and the testbench shell; no DPI-C calls inside, so it also runs on emulation platforms.

Parameters:
- NUM_CORES, 2, number of harts monitored (1..16)
- STEP_W, 8, width of each core's step field
- CNT_W, 64, width of the cycle/stuck counters and limits
- UART_DEPTH, 16, UART FIFO entries (power of 2, >=2)

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- step  in  NUM_CORES*STEP_W  per-core committed-instruction count this cycle
- exit_code  in  NUM_CORES*64  per-core exit: 0 running, all-ones normal exit, other = error
- uart_valid  in  NUM_CORES  per-core UART byte valid
- uart_ch  in  NUM_CORES*8  per-core UART byte
- max_cycles  in  CNT_W  0 = unlimited
- stuck_limit  in  CNT_W  0 = disabled
- simv_result  in  8  DPI result: 1 DONE, 2 FAIL, else none
- uo_valid  out  1  UART stream valid
- uo_ready  in  1  UART stream ready
- uo_ch  out  8  UART byte
- uo_core  out  $clog2(NUM_CORES)  source core of byte
- state  out  2  0 IDLE, 1 RUN, 2 PASS, 3 FAIL
- cause  out  3  0 none, 1 exit-ok, 2 exit-err, 3 max-cycles, 4 stuck, 5 simv-fail, 6 simv-done
- cause_core  out  $clog2(NUM_CORES)  core responsible (0 for global causes)
- err_code  out  64  latched exit_code of failing core
- n_cycles  out  CNT_W  cycles since leaving reset
- uart_drops  out  16  saturating count of dropped bytes
- perf_dump  out  1  single-cycle pulse on entering PASS or FAIL

Behaviour:
- Reset: every output 0, state IDLE, FIFO empty, all counters 0.
- IDLE->RUN on first cycle after reset deasserts; n_cycles increments in RUN only, saturates at all-ones.
- Per-core stuck_timer[i]: cleared when step[i]!=0, else +1 (saturating). Checked only in RUN.
- Termination checks each RUN cycle, priority high->low, lowest core index wins within a class:
  - exit-err -> FAIL
  - simv-fail -> FAIL
  - stuck (stuck_limit>0 && timer>=limit) -> FAIL
  - max-cycles (max_cycles>0 && n_cycles>=max_cycles) -> FAIL
  - exit-ok (all cores all-ones) -> PASS
  - simv-done -> PASS
- Only a subset of cores exiting all-ones is not a pass; keep RUN.
- Transition takes effect next cycle. cause, cause_core and err_code latch in the same edge. PASS/FAIL are sticky until reset.
- perf_dump: high exactly one cycle, the first cycle state is PASS/FAIL.
- UART path:
  - Round-robin arbiter picks one valid core per cycle; the pointer advances past the granted core.
  - A non-granted valid byte is dropped and counted, as is a grant while the FIFO is full. uart_drops +1 per dropped byte, saturating at 0xFFFF.
  - FIFO holds {core, ch}. uo_valid = !empty; pop on uo_valid&&uo_ready.
  - Simultaneous push/pop when full: pop then push, no drop.
  - Enqueue continues in PASS/FAIL so the final messages drain.
  - Fall-through latency: byte visible on uo_* one cycle after uart_valid.
- Reset mid-run: all state, FIFO contents and latches cleared on the same edge.

Optional Feature:
- Macro DIFFTEST_SIM_MONITOR_INSTR_LIMIT_EN.
- When defined:
  - Adds port max_instrs in CNT_W and output n_instrs CNT_W.
  - n_instrs accumulates the sum of all step fields in RUN, saturating.
  - max_instrs>0 && n_instrs>=max_instrs -> PASS with cause 7, ranked below exit-ok.
- When undefined: neither port exists and the cause-7 encoding is never produced.

Decomposition:
- Package difftest_sim_monitor_pkg:
  - state_e enum
  - cause_e enum
  - EXIT_OK constant (64'hFFFF_FFFF_FFFF_FFFF)
  - SIMV_DONE and SIMV_FAIL constants (8'h1, 8'h2)
- Sub-module difftest_uart_fifo: parametrised sync FIFO (WIDTH, DEPTH) with full/empty and push/pop, instantiated once for the UART path.

Test Plan:
- Reset 3 cycles, then idle with stuck_limit=0, max_cycles=0 -> state goes 0 to 1 on the first non-reset cycle; n_cycles=10 after 10 RUN cycles; all outputs 0 during reset.
- Core1 exit_code=0x5 at cycle 20 -> state=3, cause=2, cause_core=1, err_code=0x5; perf_dump exactly one cycle; later exit all-ones does not change state.
- stuck_limit=50, core0 steps each cycle, core1 never steps -> FAIL, cause=4, cause_core=1 at the cycle stuck_timer[1] reaches 50; step pulses on core1 every 40 cycles prevent FAIL.
- Core0 exits all-ones at cycle 30, core1 at cycle 45 -> RUN until cycle 45, then PASS, cause=1.
- Both cores emit UART every cycle for 40 cycles with uo_ready=0 -> 16 entries stored, alternating cores, uart_drops=64; raising uo_ready drains 16 bytes in order.
- max_cycles=100 and simv_result=2 asserted in the same cycle n_cycles=100 -> cause=5 (simv-fail outranks max-cycles).
